// File: rtl/logic_unit_pkg.sv
// logic_unit_pkg: opcodes, state encoding and beat-count helper shared by the logic unit
package logic_unit_pkg;

    localparam logic [2:0] OP_AND   = 3'd0;
    localparam logic [2:0] OP_OR    = 3'd1;
    localparam logic [2:0] OP_XOR   = 3'd2;
    localparam logic [2:0] OP_NAND  = 3'd3;
    localparam logic [2:0] OP_NOR   = 3'd4;
    localparam logic [2:0] OP_XNOR  = 3'd5;
    localparam logic [2:0] OP_ORACC = 3'd6;
    localparam logic [2:0] OP_RSVD  = 3'd7;

    localparam logic [7:0] BEATS_MAX = 8'd255;

    // ST_HOLD is carried by the orthogonal out_valid flag, not by the state register
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == BEATS_MAX) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/logic_reduce.sv
// logic_reduce: bitwise reduction of NUM_IN operands selected by opcode
module logic_reduce
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic [NUM_IN*WIDTH-1:0] operands,
    input  logic [2:0]              op,
    output logic [WIDTH-1:0]        result
);

    logic [WIDTH-1:0] r_and, r_or, r_xor;

    // fold every operand into the three base reductions
    always_comb begin
        r_and = '1;
        r_or  = '0;
        r_xor = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            r_and = r_and & operands[k*WIDTH +: WIDTH];
            r_or  = r_or  | operands[k*WIDTH +: WIDTH];
            r_xor = r_xor ^ operands[k*WIDTH +: WIDTH];
        end
    end

    // pick the opcode's reduction; accumulate beats contribute their OR, reserved gives zero
    always_comb begin
        case (op)
            OP_AND:   result = r_and;
            OP_OR:    result = r_or;
            OP_XOR:   result = r_xor;
            OP_NAND:  result = ~r_and;
            OP_NOR:   result = ~r_or;
            OP_XNOR:  result = ~r_xor;
            OP_ORACC: result = r_or;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/logic_unit.sv
// logic_unit: handshaked bitwise reduction unit with OR-accumulate groups
module logic_unit
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [2:0]              in_op,
    input  logic                    in_last,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_err,
    output logic [7:0]              out_beats
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] acc, acc_nxt, acc_base, red, data_nxt;
    logic [7:0]       cnt, cnt_nxt, cnt_base, beats_nxt;
    logic             accept, fold, emit, valid_nxt, err_nxt;

    logic_reduce #(
        .WIDTH  (WIDTH),
        .NUM_IN (NUM_IN)
    ) u_reduce (
        .operands (in_data),
        .op       (in_op),
        .result   (red)
    );

    assign in_ready = !out_valid | out_ready;
    assign accept   = in_valid & in_ready;
    assign fold     = accept & (in_op == OP_ORACC) & !in_last;
    assign emit     = accept & !fold;
    assign acc_base = (state == ST_ACCUM) ? acc : '0;
    assign cnt_base = (state == ST_ACCUM) ? cnt : 8'd0;

    // state, accumulator and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            acc       <= '0;
            cnt       <= 8'd0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_err   <= 1'b0;
            out_beats <= 8'd0;
        end else begin
            state     <= state_nxt;
            acc       <= acc_nxt;
            cnt       <= cnt_nxt;
            out_valid <= valid_nxt;
            out_data  <= data_nxt;
            out_err   <= err_nxt;
            out_beats <= beats_nxt;
        end
    end

    // non-last accumulate beats extend the group; any other accepted beat closes or discards it
    always_comb begin
        state_nxt = state;
        acc_nxt   = acc;
        cnt_nxt   = cnt;
        if (fold) begin
            state_nxt = ST_ACCUM;
            acc_nxt   = acc_base | red;
            cnt_nxt   = sat_inc(cnt_base);
        end else if (emit) begin
            state_nxt = ST_IDLE;
            acc_nxt   = '0;
            cnt_nxt   = 8'd0;
        end
    end

    // result held until taken; an emitting beat loads a fresh result in the same cycle
    always_comb begin
        valid_nxt = out_valid & !out_ready;
        data_nxt  = out_data;
        err_nxt   = out_err;
        beats_nxt = out_beats;
        if (emit) begin
            valid_nxt = 1'b1;
            data_nxt  = (in_op == OP_ORACC) ? (acc_base | red) : red;
            err_nxt   = (in_op == OP_RSVD);
            beats_nxt = (in_op == OP_ORACC) ? sat_inc(cnt_base) : 8'd1;
        end
    end

endmodule
